fpro_gpi_edge: RTL and testbench
================================

Name: fpro_gpi_edge

Overview:
- Parametrised general-purpose input port with an Avalon-MM slave, for USB/button/status inputs in the fpro system.
- Next-generation input PIO: WIDTH-bit input, multi-stage synchroniser, per-bit debounce, edge capture with write-1-to-clear, per-bit interrupt mask and an irq output.
- Sits between asynchronous board pins and the system interconnect, with read latency 1.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (2..4).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the debounced value changes; 0 bypasses debounce.
- EDGE_TYPE, 0, edge type captured: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  word register select.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous input pins.
- irq  out  1  level interrupt.

Behaviour:
- Register map (unused upper bits read 0, ignored on write):
  - Address 0: DATA, read-only, debounced value.
  - Address 1: reserved, reads 0.
  - Address 2: IRQMASK, read/write.
  - Address 3: EDGECAP, read, write-1-to-clear.
- Reset (reset_n low, asynchronous): all synchroniser flops, debounced value, previous-value register, debounce counters, IRQMASK, EDGECAP and readdata go to 0. irq is therefore 0.
- Synchroniser: in_port passes through SYNC_STAGES flops per bit, giving s.
- Debounce, DEBOUNCE_CYCLES = 0: deb = s (combinational).
- Debounce, DEBOUNCE_CYCLES > 0: per-bit counter of width max(1, clog2(DEBOUNCE_CYCLES)).
  - Each edge with s != deb: if cnt == DEBOUNCE_CYCLES-1, then deb <= s and cnt <= 0; otherwise cnt++.
  - Each edge with s == deb: cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes deb.
- Edge detect: prev <= deb every clock.
  - Event per bit: rising = deb & ~prev; falling = ~deb & prev; any = deb ^ prev, selected by EDGE_TYPE.
- EDGECAP:
  - Bit sets on the edge following its event.
  - Write to address 3 clears the bits where writedata = 1.
  - Simultaneous clear and new event on the same bit: the set wins, bit stays 1.
  - Bits stay sticky until cleared.
- IRQMASK: loaded from writedata[WIDTH-1:0] on chipselect & write & address == 2.
- irq = OR of (EDGECAP & IRQMASK), combinational from registered bits.
  - Unmasking a bit that is already captured raises irq in the same cycle the mask register updates.
- Read:
  - readdata <= the mux of the current address, every clock (no read strobe needed); valid one cycle after address is presented.
  - A read of EDGECAP in the same cycle as its clear returns the pre-clear value.
- Latency: when in_port changes and is first sampled at edge k, DATA in readdata and the EDGECAP bit both update at edge k + SYNC_STAGES + DEBOUNCE_CYCLES.
- Boundary conditions:
  - Inputs held high through reset produce a rising-edge capture after reset release; software clears EDGECAP after init.
  - Writes to addresses 0 and 1 have no effect.
  - Reset mid-debounce discards the count.

Decomposition:
- Package fpro_gpi_pkg:
  - Register address constants ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3.
  - EDGE_RISE / EDGE_FALL / EDGE_ANY constants.
- Sub-module fpro_gpi_debounce: one bit, holding the synchroniser plus the debounce counter, parametrised by SYNC_STAGES and DEBOUNCE_CYCLES. Generated WIDTH times.
- The top level holds edge detect, registers, the read mux and irq.

Test Plan:
- Reset with in_port = 0: readdata, irq, IRQMASK and EDGECAP all 0. Then WIDTH=4, SYNC=2, DEB=0: set in_port[0]=1 sampled at edge k -> DATA reads 0x1 at k+2, EDGECAP reads 0x1, irq stays 0 (mask 0).
- DEB=4, EDGE_TYPE=0: 3-cycle pulse on in_port[2] -> DATA and EDGECAP stay 0. Then hold 1 -> DATA=0x4 exactly at edge k+6; falling edge not captured.
- IRQMASK=0x5, rise on bit 2 -> irq=1. Write EDGECAP 0x4 -> irq=0 next cycle. Then write 0x1 (no bit-0 edge) -> no change.
- Write-1-to-clear of bit 1 on the same edge bit 1 sets (EDGE_TYPE=2, toggle) -> EDGECAP bit 1 remains 1.
- EDGE_TYPE=1, in_port=0xF held through reset, then drop to 0x0 -> EDGECAP=0xF and DATA=0x0. Address 1 reads 0. Assert reset_n mid-debounce -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/fpro_gpi_pkg.sv
// Shared register map and edge-type constants for the fpro general-purpose input port.
package fpro_gpi_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/fpro_gpi_edge_if.sv
// Avalon-MM slave bus bundle for the fpro input port (read latency 1).
interface fpro_gpi_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write, writedata, input readdata);
  modport slave  (input address, chipselect, write, writedata, output readdata);
endinterface

// File: rtl/fpro_gpi_debounce.sv
// One input bit: multi-stage synchroniser followed by an optional stable-count debouncer.
module fpro_gpi_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic deb
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], pin};
  end

  assign s = sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb = s;
    end else begin : g_count
      localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          deb_q;

      // Any cycle where the synchronised value agrees with deb restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          deb_q <= 1'b0;
        end else if (s != deb_q) begin
          if (cnt == LAST) begin
            deb_q <= s;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end

      assign deb = deb_q;
    end
  endgenerate

endmodule

// File: rtl/fpro_gpi_edge.sv
// fpro GPI top: per-bit sync/debounce, edge capture (W1C), interrupt mask and registered read mux.
module fpro_gpi_edge
  import fpro_gpi_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset_n,
  fpro_gpi_edge_if.slave    avs,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] event_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_next;
  logic             wr_mask;
  logic             wr_cap;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fpro_gpi_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .deb     (deb[i])
    );
  end

  always_comb begin
    if (EDGE_TYPE == EDGE_FALL)     event_bits = ~deb & prev;
    else if (EDGE_TYPE == EDGE_ANY) event_bits = deb ^ prev;
    else                            event_bits = deb & ~prev;
  end

  assign wr_mask      = avs.chipselect & avs.write & (avs.address == ADDR_IRQMASK);
  assign wr_cap       = avs.chipselect & avs.write & (avs.address == ADDR_EDGECAP);
  assign clr_bits     = wr_cap ? avs.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^avs.writedata;

  // New events are OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= '0;
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      prev    <= deb;
      edgecap <= (edgecap & ~clr_bits) | event_bits;
      if (wr_mask) irqmask <= avs.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (avs.address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = deb;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs.readdata <= '0;
    else          avs.readdata <= rd_next;
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_fpro_gpi_edge.sv
// Scoreboard bench for fpro_gpi_edge: three parameterisations, directed stimulus, negedge monitor.
module tb_fpro_gpi_edge;
  import fpro_gpi_pkg::*;

  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;

  typedef struct {
    int unsigned due;
    int          dut;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  in0, in1, in2;
  logic        irq0, irq1, irq2;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;
  exp_t        sb[$];

  fpro_gpi_edge_if bus0 ();
  fpro_gpi_edge_if bus1 ();
  fpro_gpi_edge_if bus2 ();

  fpro_gpi_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_ANY)) u_any (
    .clk(clk), .reset_n(reset_n), .avs(bus0), .in_port(in0), .irq(irq0));
  fpro_gpi_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISE)) u_deb (
    .clk(clk), .reset_n(reset_n), .avs(bus1), .in_port(in1), .irq(irq1));
  fpro_gpi_edge #(.WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_FALL)) u_fall (
    .clk(clk), .reset_n(reset_n), .avs(bus2), .in_port(in2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [31:0] actual(int dut, int kind);
    logic [31:0] v;
    v = '0;
    case (dut)
      0: v = (kind == K_IRQ) ? {31'd0, irq0} : bus0.readdata;
      1: v = (kind == K_IRQ) ? {31'd0, irq1} : bus1.readdata;
      default: v = (kind == K_IRQ) ? {31'd0, irq2} : bus2.readdata;
    endcase
    return v;
  endfunction

  // Monitor: compares every scoreboard entry that falls due in this cycle.
  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          got = actual(sb[i].dut, sb[i].kind);
          n_checks++;
          if (got !== sb[i].exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d cycle %0d): got 0x%08h, required 0x%08h",
                     sb[i].name, sb[i].dut, cyc, got, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic push(int dut, int kind, logic [31:0] exp, int unsigned off, string name);
    exp_t e;
    e.due  = cyc + off;
    e.dut  = dut;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(int dut, logic [1:0] a, logic cs, logic we, logic [31:0] d);
    case (dut)
      0: begin bus0.address = a; bus0.chipselect = cs; bus0.write = we; bus0.writedata = d; end
      1: begin bus1.address = a; bus1.chipselect = cs; bus1.write = we; bus1.writedata = d; end
      default: begin bus2.address = a; bus2.chipselect = cs; bus2.write = we; bus2.writedata = d; end
    endcase
  endtask

  task automatic sel(int dut, logic [1:0] a);
    drive(dut, a, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic wr(int dut, logic [1:0] a, logic [31:0] d);
    drive(dut, a, 1'b1, 1'b1, d);
    tick(1);
    drive(dut, a, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic rd(int dut, logic [1:0] a, logic [31:0] exp, string name);
    sel(dut, a);
    push(dut, K_RD, exp, 1, name);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    in0 = 4'h0; in1 = 4'h0; in2 = 4'hF;
    for (int d = 0; d < 3; d++) drive(d, ADDR_DATA, 1'b0, 1'b0, 32'd0);
    tick(3);

    n_checks++;
    if (bus0.readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_direct_rd0: got 0x%08h, required 0x00000000", bus0.readdata);
    end
    n_checks++;
    if (bus1.readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_direct_rd1: got 0x%08h, required 0x00000000", bus1.readdata);
    end
    n_checks++;
    if (bus2.readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_direct_rd2: got 0x%08h, required 0x00000000", bus2.readdata);
    end
    n_checks++;
    if (irq0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_direct_irq0: got %b, required 0", irq0);
    end
    n_checks++;
    if (irq1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_direct_irq1: got %b, required 0", irq1);
    end
    n_checks++;
    if (irq2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_direct_irq2: got %b, required 0", irq2);
    end

    for (int d = 0; d < 3; d++) begin
      push(d, K_RD, 32'd0, 0, "rst_rd");
      push(d, K_IRQ, 32'd0, 0, "rst_irq");
    end
    reset_n = 1'b1;

    rd(0, ADDR_IRQMASK, 32'd0, "rst_mask");
    rd(0, ADDR_EDGECAP, 32'd0, "rst_cap");
    tick(4);
    rd(2, ADDR_EDGECAP, 32'd0, "fall_hold_nocap");
    rd(2, ADDR_DATA, 32'hF, "fall_hold_data");

    // Two-flop sync, no debounce: DATA appears two edges after first sample.
    sel(0, ADDR_DATA);
    in0 = 4'h1;
    push(0, K_RD, 32'd0, 2, "lat0_early");
    push(0, K_RD, 32'd1, 3, "lat0_data");
    push(0, K_IRQ, 32'd0, 4, "irq_masked");
    tick(3);
    rd(0, ADDR_EDGECAP, 32'd1, "cap_rise");

    wr(0, ADDR_EDGECAP, 32'hF);
    in0 = 4'h3;
    tick(2);
    wr(0, ADDR_EDGECAP, 32'h2);
    rd(0, ADDR_EDGECAP, 32'h2, "w1c_collide");

    push(0, K_IRQ, 32'd0, 0, "irq_pre_unmask");
    push(0, K_IRQ, 32'd1, 1, "irq_unmask");
    wr(0, ADDR_IRQMASK, 32'hFFFF_FFF2);
    rd(0, ADDR_IRQMASK, 32'h2, "mask_upper_ignored");

    wr(0, ADDR_DATA, 32'hFFFF_FFFF);
    wr(0, ADDR_RSVD, 32'hFFFF_FFFF);
    rd(0, ADDR_RSVD, 32'd0, "rsvd_zero");
    rd(0, ADDR_DATA, 32'h3, "data_nowrite");
    rd(0, ADDR_EDGECAP, 32'h2, "cap_nowrite");
    rd(0, ADDR_IRQMASK, 32'h2, "mask_nowrite");

    // Debounce of 4: a 3-cycle pulse must never reach DATA.
    sel(1, ADDR_DATA);
    in1 = 4'h4;
    for (int i = 1; i <= 12; i++) push(1, K_RD, 32'd0, i, "glitch_rd");
    tick(3);
    in1 = 4'h0;
    tick(10);
    rd(1, ADDR_DATA, 32'd0, "glitch_data");
    rd(1, ADDR_EDGECAP, 32'd0, "glitch_cap");

    wr(1, ADDR_IRQMASK, 32'h5);
    sel(1, ADDR_DATA);
    in1 = 4'h4;
    push(1, K_RD, 32'd0, 6, "deb_lat_early");
    push(1, K_RD, 32'h4, 7, "deb_lat_data");
    push(1, K_IRQ, 32'd0, 6, "deb_irq_early");
    push(1, K_IRQ, 32'd1, 7, "deb_irq");
    tick(7);
    rd(1, ADDR_EDGECAP, 32'h4, "deb_cap");

    push(1, K_RD, 32'h4, 1, "cap_preclear");
    push(1, K_IRQ, 32'd1, 0, "irq_before_clr");
    push(1, K_IRQ, 32'd0, 1, "irq_clr");
    wr(1, ADDR_EDGECAP, 32'h4);
    wr(1, ADDR_EDGECAP, 32'h1);
    push(1, K_IRQ, 32'd0, 0, "irq_w1c_noop");
    rd(1, ADDR_EDGECAP, 32'd0, "cap_w1c_noop");

    in1 = 4'h0;
    tick(10);
    rd(1, ADDR_EDGECAP, 32'd0, "fall_nocap");
    rd(1, ADDR_DATA, 32'd0, "fall_data");

    in2 = 4'h0;
    tick(6);
    rd(2, ADDR_DATA, 32'd0, "fall_data2");
    rd(2, ADDR_EDGECAP, 32'hF, "fall_cap");
    rd(2, ADDR_RSVD, 32'd0, "rsvd2");

    // Reset lands between edges while bit 3 of dut1 is part-way through its count.
    sel(0, ADDR_EDGECAP);
    sel(1, ADDR_IRQMASK);
    in1 = 4'h8;
    tick(3);
    push(0, K_RD, 32'h2, 0, "pre_arst_rd0");
    push(0, K_IRQ, 32'd1, 0, "pre_arst_irq0");
    push(1, K_RD, 32'h5, 0, "pre_arst_rd1");
    tick(1);
    reset_n = 1'b0;
    push(0, K_RD, 32'd0, 0, "arst_rd0");
    push(0, K_IRQ, 32'd0, 0, "arst_irq0");
    push(1, K_RD, 32'd0, 0, "arst_rd1");
    tick(2);
    reset_n = 1'b1;
    sel(1, ADDR_DATA);
    push(1, K_RD, 32'd0, 6, "arst_cnt_early");
    push(1, K_RD, 32'h8, 7, "arst_cnt_data");
    push(0, K_RD, 32'd0, 3, "hold_rst_cap_early");
    push(0, K_RD, 32'h3, 4, "hold_rst_cap");
    push(0, K_IRQ, 32'd0, 5, "irq_after_rst");
    tick(8);

    tick(2);
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no comparison at cycle %0d, required one", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
